// File: rtl/conv_pool_engine.sv
`default_nettype none
// ============================================================================
// Module  : conv_pool_engine
// Brief   : 3x3 conv + bias + round/saturate + ReLU, then optional 2x2 max-pool.
// Revision: 1.0
// ============================================================================
module conv_pool_engine #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int DW      = 20,
    parameter int FRAC    = 16,
    parameter int ADDR_W  = 12,
    parameter int POOL_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    input  logic              kwr,
    input  logic [3:0]        kaddr,
    input  logic [DW-1:0]     kdata,
    output logic [ADDR_W-1:0] iaddr,
    input  logic [DW-1:0]     idata,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DW-1:0]     cdata_wr,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DW-1:0]     cdata_rd,
    output logic [2:0]        csel
);

    localparam int c_ACC_W = 2*DW + 4;
    localparam int c_PW    = 2*DW;
    localparam int c_CW    = $clog2(IMG_W);
    localparam int c_RW    = $clog2(IMG_H);
    localparam logic signed [c_ACC_W:0] c_HALF = (c_ACC_W+1)'(64'sd1 <<< (FRAC-1));
    localparam logic signed [c_ACC_W:0] c_MAX  = (c_ACC_W+1)'((64'sd1 <<< (DW-1)) - 64'sd1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_ROUND  = 3'd2;
    localparam logic [2:0] S_WRITE0 = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_WRITE1 = 3'd5;
    localparam logic [2:0] S_END    = 3'd6;

    logic [2:0]                r_state;
    logic [2:0]                w_next;
    logic signed [DW-1:0]      r_coef [0:9];
    logic [3:0]                r_tap;
    logic [1:0]                r_rd;
    logic [c_RW-1:0]           r_row;
    logic [c_CW-1:0]           r_col;
    logic signed [c_ACC_W-1:0] r_acc;
    logic [DW-1:0]             r_result;
    logic [DW-1:0]             r_max;

    logic                      w_last_pix;
    logic                      w_last_out;
    int                        w_yy;
    int                        w_xx;
    logic                      w_in;
    logic [ADDR_W-1:0]         w_iaddr;
    logic signed [c_PW-1:0]    w_ka;
    logic signed [c_PW-1:0]    w_xa;
    logic signed [c_PW-1:0]    w_prod;
    logic signed [c_ACC_W:0]   w_full;
    logic signed [c_ACC_W:0]   w_rnd;
    logic [DW-1:0]             w_sat;
    logic [ADDR_W-1:0]         w_pix_addr;
    logic [ADDR_W-1:0]         w_pool_addr;
    logic [ADDR_W-1:0]         w_raddr;

    assign w_last_pix = (r_row == c_RW'(IMG_H-1)) && (r_col == c_CW'(IMG_W-1));
    assign w_last_out = (r_row == c_RW'(IMG_H/2-1)) && (r_col == c_CW'(IMG_W/2-1));

    // Tap k sits at (dy,dx) = (k/3-1, k%3-1); off-image taps are masked out.
    always_comb begin
        w_yy    = int'(r_row) + (int'(r_tap) / 3) - 1;
        w_xx    = int'(r_col) + (int'(r_tap) % 3) - 1;
        w_in    = (w_yy >= 0) && (w_yy < IMG_H) && (w_xx >= 0) && (w_xx < IMG_W);
        w_iaddr = w_in ? ADDR_W'(w_yy*IMG_W + w_xx) : '0;
        w_ka    = c_PW'(r_coef[r_tap]);
        w_xa    = c_PW'($signed(idata));
        w_prod  = w_in ? (w_ka * w_xa) : '0;
    end

    always_comb begin
        w_full = (c_ACC_W+1)'(r_acc) + ((c_ACC_W+1)'(r_coef[9]) <<< FRAC) + c_HALF;
        w_rnd  = w_full >>> FRAC;
        if (w_rnd[c_ACC_W])
            w_sat = '0;
        else if (w_rnd > c_MAX)
            w_sat = c_MAX[DW-1:0];
        else
            w_sat = w_rnd[DW-1:0];
    end

    assign w_pix_addr  = ADDR_W'(int'(r_row)*IMG_W + int'(r_col));
    assign w_pool_addr = ADDR_W'(int'(r_row)*(IMG_W/2) + int'(r_col));
    assign w_raddr     = ADDR_W'((2*int'(r_row) + int'(r_rd[1]))*IMG_W
                                 + 2*int'(r_col) + int'(r_rd[0]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (ready) w_next = S_FETCH;
            S_FETCH:  if (r_tap == 4'd8) w_next = S_ROUND;
            S_ROUND:  w_next = S_WRITE0;
            S_WRITE0: begin
                if (w_last_pix)
                    w_next = (POOL_EN != 0) ? S_READ : S_END;
                else
                    w_next = S_FETCH;
            end
            S_READ:   if (r_rd == 2'd3) w_next = S_WRITE1;
            S_WRITE1: w_next = w_last_out ? S_END : S_READ;
            S_END:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 10; i++)
                r_coef[i] <= '0;
            r_tap    <= '0;
            r_rd     <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_max    <= '0;
        end else begin
            if ((r_state == S_IDLE) && kwr && (kaddr <= 4'd9))
                r_coef[kaddr] <= kdata;
            case (r_state)
                S_IDLE: begin
                    if (ready) begin
                        r_tap <= '0;
                        r_rd  <= '0;
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                S_FETCH: begin
                    r_acc <= ((r_tap == 4'd0) ? '0 : r_acc) + c_ACC_W'(w_prod);
                    r_tap <= (r_tap == 4'd8) ? 4'd0 : r_tap + 4'd1;
                end
                S_ROUND: r_result <= w_sat;
                S_WRITE0: begin
                    if (w_last_pix) begin
                        r_row <= '0;
                        r_col <= '0;
                    end else if (r_col == c_CW'(IMG_W-1)) begin
                        r_col <= '0;
                        r_row <= r_row + c_RW'(1);
                    end else begin
                        r_col <= r_col + c_CW'(1);
                    end
                end
                S_READ: begin
                    // Post-ReLU values are non-negative, so unsigned compare suffices.
                    if ((r_rd == 2'd0) || (cdata_rd > r_max))
                        r_max <= cdata_rd;
                    r_rd <= r_rd + 2'd1;
                end
                S_WRITE1: begin
                    if (w_last_out) begin
                        r_row <= '0;
                        r_col <= '0;
                    end else if (r_col == c_CW'(IMG_W/2-1)) begin
                        r_col <= '0;
                        r_row <= r_row + c_RW'(1);
                    end else begin
                        r_col <= r_col + c_CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        iaddr    = '0;
        cwr      = 1'b0;
        caddr_wr = '0;
        cdata_wr = '0;
        crd      = 1'b0;
        caddr_rd = '0;
        csel     = 3'b000;
        case (r_state)
            S_FETCH: begin
                busy  = 1'b1;
                iaddr = w_iaddr;
            end
            S_ROUND: busy = 1'b1;
            S_WRITE0: begin
                busy     = 1'b1;
                cwr      = 1'b1;
                csel     = 3'b001;
                caddr_wr = w_pix_addr;
                cdata_wr = r_result;
            end
            S_READ: begin
                busy     = 1'b1;
                crd      = 1'b1;
                csel     = 3'b001;
                caddr_rd = w_raddr;
            end
            S_WRITE1: begin
                busy     = 1'b1;
                cwr      = 1'b1;
                csel     = 3'b011;
                caddr_wr = w_pool_addr;
                cdata_wr = r_max;
            end
            S_END: done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_pool_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_pool_engine
// Brief   : Self-checking bench; pooled and non-pooled 4x4 engines vs. arithmetic model.
// Revision: 1.0
// ============================================================================
module tb_conv_pool_engine;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int DW   = 20;
    localparam int AW   = 12;
    localparam int NPIX = W*H;
    localparam int NOUT = (W/2)*(H/2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          ready = 1'b0;
    logic          kwr   = 1'b0;
    logic [3:0]    kaddr = '0;
    logic [DW-1:0] kdata = '0;
    logic          clr_req = 1'b0;

    logic          busy_a, done_a, cwr_a, crd_a, busy_b, done_b, cwr_b, crd_b;
    logic [AW-1:0] iaddr_a, caddr_wr_a, caddr_rd_a, iaddr_b, caddr_wr_b, caddr_rd_b;
    logic [DW-1:0] idata_a, cdata_wr_a, cdata_rd_a, idata_b, cdata_wr_b, cdata_rd_b;
    logic [2:0]    csel_a, csel_b;

    logic [DW-1:0] img  [0:NPIX-1];
    logic [DW-1:0] kv   [0:9];
    logic [DW-1:0] l0_a [0:NPIX-1];
    logic [DW-1:0] l1_a [0:NOUT-1];
    logic [DW-1:0] l0_b [0:NPIX-1];
    logic [DW-1:0] l1_b [0:NOUT-1];
    logic [DW-1:0] exp0 [0:NPIX-1];
    logic [DW-1:0] exp1 [0:NOUT-1];
    int wr0_a, wr1_a, wr0_b, wr1_b, dn_a, dn_b, viol;
    int nvec = 0;
    int nerr = 0;

    conv_pool_engine #(.IMG_W(W), .IMG_H(H), .DW(DW), .FRAC(16), .ADDR_W(AW), .POOL_EN(1)) u_pool (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy_a), .done(done_a),
        .kwr(kwr), .kaddr(kaddr), .kdata(kdata), .iaddr(iaddr_a), .idata(idata_a),
        .cwr(cwr_a), .caddr_wr(caddr_wr_a), .cdata_wr(cdata_wr_a),
        .crd(crd_a), .caddr_rd(caddr_rd_a), .cdata_rd(cdata_rd_a), .csel(csel_a));

    conv_pool_engine #(.IMG_W(W), .IMG_H(H), .DW(DW), .FRAC(16), .ADDR_W(AW), .POOL_EN(0)) u_nopool (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy_b), .done(done_b),
        .kwr(kwr), .kaddr(kaddr), .kdata(kdata), .iaddr(iaddr_b), .idata(idata_b),
        .cwr(cwr_b), .caddr_wr(caddr_wr_b), .cdata_wr(cdata_wr_b),
        .crd(crd_b), .caddr_rd(caddr_rd_b), .cdata_rd(cdata_rd_b), .csel(csel_b));

    assign idata_a    = img[iaddr_a[3:0]];
    assign idata_b    = img[iaddr_b[3:0]];
    assign cdata_rd_a = l0_a[caddr_rd_a[3:0]];
    assign cdata_rd_b = l0_b[caddr_rd_b[3:0]];

    logic bad_a, bad_b;
    assign bad_a = (cwr_a && crd_a) || (!cwr_a && !crd_a && csel_a != 3'b000) || (busy_a && done_a)
                || (iaddr_a >= AW'(NPIX)) || (crd_a && caddr_rd_a >= AW'(NPIX))
                || (cwr_a && csel_a == 3'b001 && caddr_wr_a >= AW'(NPIX))
                || (cwr_a && csel_a == 3'b011 && caddr_wr_a >= AW'(NOUT));
    assign bad_b = (cwr_b && crd_b) || (!cwr_b && !crd_b && csel_b != 3'b000) || (busy_b && done_b)
                || (iaddr_b >= AW'(NPIX)) || (crd_b && caddr_rd_b >= AW'(NPIX))
                || (cwr_b && csel_b == 3'b001 && caddr_wr_b >= AW'(NPIX))
                || (cwr_b && csel_b == 3'b011 && caddr_wr_b >= AW'(NOUT));

    // Layer RAMs plus bus-rule monitor; cleared on request before each job.
    always @(posedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < NPIX; i++) begin
                l0_a[i] <= 20'hAAAAA;
                l0_b[i] <= 20'hAAAAA;
            end
            for (int i = 0; i < NOUT; i++) begin
                l1_a[i] <= 20'hAAAAA;
                l1_b[i] <= 20'hAAAAA;
            end
            wr0_a <= 0; wr1_a <= 0; wr0_b <= 0; wr1_b <= 0;
            dn_a <= 0; dn_b <= 0; viol <= 0;
        end else begin
            if (cwr_a && csel_a == 3'b001) begin l0_a[caddr_wr_a[3:0]] <= cdata_wr_a; wr0_a <= wr0_a + 1; end
            if (cwr_a && csel_a == 3'b011) begin l1_a[caddr_wr_a[1:0]] <= cdata_wr_a; wr1_a <= wr1_a + 1; end
            if (cwr_b && csel_b == 3'b001) begin l0_b[caddr_wr_b[3:0]] <= cdata_wr_b; wr0_b <= wr0_b + 1; end
            if (cwr_b && csel_b == 3'b011) begin l1_b[caddr_wr_b[1:0]] <= cdata_wr_b; wr1_b <= wr1_b + 1; end
            if (done_a) dn_a <= dn_a + 1;
            if (done_b) dn_b <= dn_b + 1;
            if (bad_a || bad_b) viol <= viol + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: direct 3x3 sum over in-image taps, exact integer rounding, clamp, 2x2 max.
    function automatic void model();
        longint s, f, r;
        int y, x;
        logic [DW-1:0] m;
        for (int rr = 0; rr < H; rr++) begin
            for (int cc = 0; cc < W; cc++) begin
                s = 0;
                for (int k = 0; k < 9; k++) begin
                    y = rr + k/3 - 1;
                    x = cc + k%3 - 1;
                    if (y >= 0 && y < H && x >= 0 && x < W)
                        s += longint'($signed(kv[k])) * longint'($signed(img[y*W+x]));
                end
                f = s + longint'($signed(kv[9])) * 65536;
                r = (f + 32768) >>> 16;
                if (r < 0) r = 0;
                if (r > 524287) r = 524287;
                exp0[rr*W+cc] = DW'(r);
            end
        end
        for (int i = 0; i < H/2; i++) begin
            for (int j = 0; j < W/2; j++) begin
                m = '0;
                for (int d = 0; d < 4; d++)
                    if (exp0[(2*i + d/2)*W + 2*j + d%2] > m) m = exp0[(2*i + d/2)*W + 2*j + d%2];
                exp1[i*(W/2)+j] = m;
            end
        end
    endfunction

    task automatic load_coefs();
        for (int k = 0; k < 10; k++) begin
            kwr = 1'b1; kaddr = 4'(k); kdata = kv[k];
            step();
        end
        kwr = 1'b0;
    endtask

    task automatic run_job(input string name, input bit disturb, input bit ld_start,
                           input logic [3:0] la, input logic [DW-1:0] ld);
        int n, ta, tb;
        clr_req = 1'b1; step(); clr_req = 1'b0;
        if (ld_start) begin
            kwr = 1'b1; kaddr = la; kdata = ld;
            if (la <= 4'd9) kv[la] = ld;
        end
        ready = 1'b1;
        step();
        ready = 1'b0; kwr = 1'b0;
        model();
        nvec++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            nerr++; $display("FAIL %s busy_after_start: got %b/%b expected 1/1", name, busy_a, busy_b);
        end
        n = 0; ta = -1; tb = -1;
        while ((ta < 0 || tb < 0) && n < 400) begin
            if (disturb && (n == 50 || n == 120)) begin
                ready = 1'b1; kwr = 1'b1; kaddr = 4'd4; kdata = 20'($urandom);
            end else begin
                ready = 1'b0; kwr = 1'b0;
            end
            step(); n++;
            if (done_a === 1'b1 && ta < 0) ta = n;
            if (done_b === 1'b1 && tb < 0) tb = n;
        end
        ready = 1'b0; kwr = 1'b0;
        step(); step();
        nvec++;
        if (ta != 11*NPIX + 5*NOUT) begin nerr++; $display("FAIL %s done_latency_pool: got %0d expected %0d", name, ta, 11*NPIX + 5*NOUT); end
        nvec++;
        if (tb != 11*NPIX) begin nerr++; $display("FAIL %s done_latency_nopool: got %0d expected %0d", name, tb, 11*NPIX); end
        nvec++;
        if (dn_a != 1 || dn_b != 1) begin nerr++; $display("FAIL %s done_pulses: got %0d/%0d expected 1/1", name, dn_a, dn_b); end
        nvec++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin nerr++; $display("FAIL %s busy_after_end: got %b/%b expected 0/0", name, busy_a, busy_b); end
        nvec++;
        if (wr0_a != NPIX || wr1_a != NOUT || wr0_b != NPIX || wr1_b != 0) begin
            nerr++; $display("FAIL %s write_counts: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,0", name, wr0_a, wr1_a, wr0_b, wr1_b, NPIX, NOUT, NPIX);
        end
        nvec++;
        if (viol != 0) begin nerr++; $display("FAIL %s bus_rules: got %0d violations expected 0", name, viol); end
        for (int i = 0; i < NPIX; i++) begin
            nvec++;
            if (l0_a[i] !== exp0[i] || l0_b[i] !== exp0[i]) begin
                nerr++; $display("FAIL %s layer0[%0d]: got %h/%h expected %h", name, i, l0_a[i], l0_b[i], exp0[i]);
            end
        end
        for (int i = 0; i < NOUT; i++) begin
            nvec++;
            if (l1_a[i] !== exp1[i]) begin nerr++; $display("FAIL %s layer1[%0d]: got %h expected %h", name, i, l1_a[i], exp1[i]); end
        end
    endtask

    task automatic test_reset();
        step(); step();
        nvec++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || cwr_a !== 1'b0 || crd_a !== 1'b0 || csel_a !== 3'b000) begin
            nerr++; $display("FAIL reset_ctrl_a: got busy=%b done=%b cwr=%b crd=%b csel=%b expected all 0", busy_a, done_a, cwr_a, crd_a, csel_a);
        end
        nvec++;
        if (iaddr_a !== '0 || caddr_wr_a !== '0 || caddr_rd_a !== '0 || cdata_wr_a !== '0) begin
            nerr++; $display("FAIL reset_bus_a: got %h %h %h %h expected 0", iaddr_a, caddr_wr_a, caddr_rd_a, cdata_wr_a);
        end
        nvec++;
        if (busy_b !== 1'b0 || done_b !== 1'b0 || cwr_b !== 1'b0 || crd_b !== 1'b0 || csel_b !== 3'b000
            || iaddr_b !== '0 || caddr_wr_b !== '0 || caddr_rd_b !== '0 || cdata_wr_b !== '0) begin
            nerr++; $display("FAIL reset_b: got busy=%b cwr=%b csel=%b expected 0", busy_b, cwr_b, csel_b);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_shift_image();
        for (int k = 0; k < 10; k++) kv[k] = '0;
        kv[4] = 20'h10000;
        for (int i = 0; i < NPIX; i++) img[i] = 20'(i * 32'h10000);
        load_coefs();
        run_job("shift_image", 1'b0, 1'b0, 4'd0, '0);
    endtask

    task automatic test_all_ones();
        for (int k = 0; k < 9; k++) kv[k] = 20'h10000;
        kv[9] = '0;
        for (int i = 0; i < NPIX; i++) img[i] = 20'h10000;
        load_coefs();
        run_job("all_ones", 1'b0, 1'b0, 4'd0, '0);
        nvec++;
        if (l0_b[0] !== 20'h40000 || l0_b[1] !== 20'h60000 || l0_b[5] !== 20'h7FFFF) begin
            nerr++; $display("FAIL all_ones_corner_edge_mid: got %h %h %h expected 40000 60000 7ffff", l0_b[0], l0_b[1], l0_b[5]);
        end
    endtask

    task automatic test_rounding();
        for (int k = 0; k < 10; k++) kv[k] = '0;
        kv[4] = 20'h08000;
        for (int i = 0; i < NPIX; i++) img[i] = (i % 2 == 0) ? 20'h00001 : 20'hFFFFF;
        load_coefs();
        run_job("rounding", 1'b0, 1'b0, 4'd0, '0);
        nvec++;
        if (l0_a[0] !== 20'h00001 || l0_a[1] !== 20'h00000) begin
            nerr++; $display("FAIL round_half_up_relu: got %h %h expected 00001 00000", l0_a[0], l0_a[1]);
        end
    endtask

    task automatic test_bias_only();
        for (int k = 0; k < 9; k++) kv[k] = '0;
        for (int i = 0; i < NPIX; i++) img[i] = 20'($urandom);
        kv[9] = 20'h01310;
        load_coefs();
        run_job("bias_pos", 1'b0, 1'b0, 4'd0, '0);
        nvec++;
        if (l0_a[7] !== 20'h01310) begin nerr++; $display("FAIL bias_pos_word: got %h expected 01310", l0_a[7]); end
        kv[9] = 20'hFFFF0;
        load_coefs();
        run_job("bias_neg", 1'b0, 1'b0, 4'd0, '0);
        nvec++;
        if (l0_a[7] !== 20'h00000) begin nerr++; $display("FAIL bias_neg_word: got %h expected 00000", l0_a[7]); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 9; k++) kv[k] = 20'($urandom_range(0, 32767)) - 20'h04000;
            kv[9] = 20'($urandom_range(0, 262143)) - 20'h20000;
            for (int i = 0; i < NPIX; i++) img[i] = 20'($urandom_range(0, 524287)) - 20'h40000;
            load_coefs();
            run_job("random", 1'b0, 1'b0, 4'd0, '0);
        end
    endtask

    task automatic test_protocol();
        for (int k = 0; k < 9; k++) kv[k] = 20'($urandom_range(0, 32767)) - 20'h04000;
        kv[9] = 20'h00800;
        for (int i = 0; i < NPIX; i++) img[i] = 20'($urandom_range(0, 524287)) - 20'h40000;
        load_coefs();
        for (int a = 10; a < 16; a++) begin
            kwr = 1'b1; kaddr = 4'(a); kdata = 20'($urandom);
            step();
        end
        kwr = 1'b0;
        run_job("mid_job_ready_kwr", 1'b1, 1'b0, 4'd0, '0);
        run_job("kwr_with_ready", 1'b0, 1'b1, 4'd9, 20'h24000);
    endtask

    task automatic test_reset_mid_conv();
        clr_req = 1'b1; step(); clr_req = 1'b0;
        ready = 1'b1; step(); ready = 1'b0;
        repeat (32) step();
        nvec++;
        if (cwr_a !== 1'b1) begin nerr++; $display("FAIL pre_abort_write: got cwr=%b expected 1", cwr_a); end
        reset = 1'b0;
        #1;
        nvec++;
        if (busy_a !== 1'b0 || cwr_a !== 1'b0 || csel_a !== 3'b000 || busy_b !== 1'b0 || cwr_b !== 1'b0 || csel_b !== 3'b000) begin
            nerr++; $display("FAIL async_abort: got busy=%b/%b cwr=%b/%b csel=%b/%b expected 0", busy_a, busy_b, cwr_a, cwr_b, csel_a, csel_b);
        end
        step();
        reset = 1'b1;
        step();
        for (int k = 0; k < 10; k++) kv[k] = '0;
        run_job("after_reset_cleared_coefs", 1'b0, 1'b0, 4'd0, '0);
    endtask

    initial begin
        test_reset();
        test_shift_image();
        test_all_ones();
        test_rounding();
        test_bias_only();
        test_random();
        test_protocol();
        test_reset_mid_conv();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
